// File: rtl/sum_accumulator.sv
// sum_accumulator
// ----------------------------------------------------------------------------
// Downstream stage of the ripple-carry adder. Accepts WIDTH+1-bit adder results
// ({carry, sum}) over a valid/ready handshake. It sums COUNT of them into one
// frame and presents that frame on a registered valid/ready output. A partial
// frame can be closed early with i_flush. An accumulator overflow is reported
// per frame.
//
// Optional feature macro: SUM_ACC_SAT_EN
//   defined   -> once a frame overflows, the accumulator clamps to 2^ACC_W-1
//                and stays there until the frame ends.
//   undefined -> the accumulator wraps modulo 2^ACC_W.
//   o_out_ovf flags overflow in both builds, and the ports are identical.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   upstream sample valid
//   o_in_ready   block can accept a sample (registered, depends only on state)
//   i_in_data    adder result {carry, sum}, unsigned, WIDTH+1 bits
//   i_flush      close the current partial frame (ignored when it is empty)
//   o_out_valid  frame result valid
//   i_out_ready  downstream accepts the frame
//   o_out_data   frame sum, ACC_W bits
//   o_out_count  number of samples in the frame
//   o_out_ovf    an accumulation overflow occurred in this frame
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module sum_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned COUNT = 4,
    parameter int unsigned CNT_W = $clog2(COUNT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH:0]   i_in_data,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_data,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_ovf
);

    localparam int unsigned SumW = ACC_W + 1;

    generate
        if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
            $error("sum_accumulator: ACC_W must be >= WIDTH+1");
        end
        if (COUNT < 1) begin : g_bad_count
            $error("sum_accumulator: COUNT must be >= 1");
        end
    endgenerate

    typedef enum logic {StAcc, StDone} state_e;

    state_e           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_ovf;

    logic             w_accept;
    logic [SumW-1:0]  w_sum;
    logic             w_ovf_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [ACC_W-1:0] w_acc_upd;
    logic [CNT_W-1:0] w_cnt_upd;
    logic             w_ovf_upd;
    logic             w_close;

    // r_in_ready is high only in StAcc, so it also gates the accept to that state.
    assign w_accept  = i_in_valid & r_in_ready;
    // One extra bit catches the carry out of the accumulator.
    assign w_sum     = {1'b0, r_acc} + SumW'(i_in_data);
    assign w_ovf_nxt = r_ovf | w_sum[ACC_W];
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

`ifdef SUM_ACC_SAT_EN
    // The sticky overflow keeps the clamp in force for the rest of the frame.
    assign w_acc_nxt = w_ovf_nxt ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    // Frame values as they stand after this cycle's beat, if there is one.
    assign w_acc_upd = w_accept ? w_acc_nxt : r_acc;
    assign w_cnt_upd = w_accept ? w_cnt_nxt : r_cnt;
    assign w_ovf_upd = w_accept ? w_ovf_nxt : r_ovf;

    // A flush on an empty frame with no beat this cycle is ignored.
    assign w_close = (r_state == StAcc) &&
                     ((w_accept && (w_cnt_nxt == CNT_W'(COUNT))) ||
                      (i_flush && ((r_cnt != '0) || w_accept)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StAcc;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                StAcc: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                    end
                    if (w_close) begin
                        r_state     <= StDone;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_acc_upd;
                        r_out_count <= w_cnt_upd;
                        r_out_ovf   <= w_ovf_upd;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_state     <= StAcc;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: r_state <= StAcc;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_count = r_out_count;
    assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Testbench for sum_accumulator.
// Instance dut_a uses the default parameters (WIDTH=16, ACC_W=20, COUNT=4).
// Instance dut_b uses ACC_W=18, so that frames can overflow.
`timescale 1ns/1ps

module tb_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_ovf;
    logic [16:0] a_in_data;
    logic [19:0] a_out_data;
    logic [2:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_ovf;
    logic [16:0] b_in_data;
    logic [17:0] b_out_data;
    logic [2:0]  b_out_count;

    int checks = 0;
    int errors = 0;

    sum_accumulator #(.WIDTH(16), .ACC_W(20), .COUNT(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
        .i_flush(a_flush),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
        .o_out_count(a_out_count), .o_out_ovf(a_out_ovf)
    );

    sum_accumulator #(.WIDTH(16), .ACC_W(18), .COUNT(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .i_flush(b_flush),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
        .o_out_count(b_out_count), .o_out_ovf(b_out_ovf)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on dut_a and hold it until it is accepted (bounded).
    task automatic send_a(input logic [16:0] d, input logic fl);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_flush    = fl;
        while (!a_in_ready && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_a_ready got %b expected 1", a_in_ready);
        end
        cyc();
        a_in_valid = 1'b0;
        a_flush    = 1'b0;
    endtask

    task automatic send_b(input logic [16:0] d, input logic fl);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_flush    = fl;
        while (!b_in_ready && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_b_ready got %b expected 1", b_in_ready);
        end
        cyc();
        b_in_valid = 1'b0;
        b_flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_flush = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({a_in_ready, a_out_valid, a_out_data, a_out_count, a_out_ovf} !== '0) begin
                errors++;
                $display("FAIL reset_a rdy=%b vld=%b data=%h cnt=%0d ovf=%b expected all 0",
                         a_in_ready, a_out_valid, a_out_data, a_out_count, a_out_ovf);
            end
            checks++;
            if ({b_in_ready, b_out_valid, b_out_data, b_out_count, b_out_ovf} !== '0) begin
                errors++;
                $display("FAIL reset_b rdy=%b vld=%b data=%h expected all 0",
                         b_in_ready, b_out_valid, b_out_data);
            end
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 1", a_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_a(17'(i), 1'b0);
            if (i < 4) begin
                checks++;
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_early_valid beat %0d got %b expected 0", i, a_out_valid);
                end
            end
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'h0000A || a_out_count !== 3'd4 ||
            a_out_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame vld=%b data=%h cnt=%0d ovf=%b rdy=%b expected 1 0000a 4 0 0",
                     a_out_valid, a_out_data, a_out_count, a_out_ovf, a_in_ready);
        end
        cyc();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_stall();
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_a(17'h1FFFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 17'h00007;
            a_flush    = (k % 2) == 1;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 20'h7FFFC || a_out_count !== 3'd4 ||
                a_out_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d vld=%b data=%h cnt=%0d ovf=%b rdy=%b expected 1 7fffc 4 0 0",
                         k, a_out_valid, a_out_data, a_out_count, a_out_ovf, a_in_ready);
            end
            cyc();
        end
        a_in_valid = 1'b0;
        a_flush    = 1'b0;
        a_out_ready = 1'b1;
        cyc();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release vld=%b rdy=%b expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b1;
        send_a(17'h00010, 1'b0);
        send_a(17'h00020, 1'b0);
        a_flush = 1'b1;
        cyc();
        a_flush = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'h00030 || a_out_count !== 3'd2 ||
            a_out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL flush_frame vld=%b data=%h cnt=%0d ovf=%b expected 1 00030 2 0",
                     a_out_valid, a_out_data, a_out_count, a_out_ovf);
        end
        cyc();
        a_flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty cyc %0d vld=%b expected 0", k, a_out_valid);
            end
        end
        a_flush = 1'b0;
    endtask

    task automatic test_flush_with_accept();
        a_out_ready = 1'b1;
        send_a(17'h00001, 1'b0);
        send_a(17'h00002, 1'b0);
        send_a(17'h00005, 1'b1);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'h00008 || a_out_count !== 3'd3) begin
            errors++;
            $display("FAIL flush_accept vld=%b data=%h cnt=%0d expected 1 00008 3",
                     a_out_valid, a_out_data, a_out_count);
        end
        cyc();
    endtask

    task automatic test_overflow();
        logic [17:0] exp_d;
`ifdef SUM_ACC_SAT_EN
        exp_d = 18'h3FFFF;
`else
        exp_d = 18'h00000;
`endif
        b_out_ready = 1'b1;
        send_b(17'h1FFFF, 1'b0);
        send_b(17'h1FFFF, 1'b0);
        send_b(17'h00002, 1'b0);
        b_flush = 1'b1;
        cyc();
        b_flush = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_ovf !== 1'b1 || b_out_data !== exp_d ||
            b_out_count !== 3'd3) begin
            errors++;
            $display("FAIL overflow vld=%b ovf=%b data=%h cnt=%0d expected 1 1 %h 3",
                     b_out_valid, b_out_ovf, b_out_data, b_out_count, exp_d);
        end
        cyc();
    endtask

    task automatic test_reset_mid_frame();
        a_out_ready = 1'b1;
        send_a(17'h00001, 1'b0);
        send_a(17'h00001, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_data, a_out_count, a_out_ovf} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs rdy=%b vld=%b data=%h cnt=%0d expected all 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_count);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) send_a(17'h00001, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 20'h00004 || a_out_count !== 3'd4 ||
            a_out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frame vld=%b data=%h cnt=%0d ovf=%b expected 1 00004 4 0",
                     a_out_valid, a_out_data, a_out_count, a_out_ovf);
        end
        cyc();
    endtask

    // Random traffic on dut_b. The reference model keeps the beats of the open
    // frame and derives the sum and the overflow from their plain total.
    task automatic test_random();
        logic [16:0] q[$];
        bit          pend = 0;
        logic [17:0] exp_d = '0;
        logic [2:0]  exp_c = '0;
        bit          exp_o = 0;
        longint      total;
        longint      lim = 64'd1 << 18;
        int unsigned r;
        bit          acc;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            b_in_valid  = (r % 4) != 0;
            r = $urandom;
            b_in_data   = ((r % 3) == 0) ? 17'h1FFFF - 17'(r % 32) : 17'(r >> 15);
            b_flush     = ($urandom % 8) == 0;
            b_out_ready = ($urandom % 3) != 0;
            checks++;
            if (b_in_ready !== !pend || b_out_valid !== pend) begin
                errors++;
                $display("FAIL rand_hs cyc %0d rdy=%b vld=%b expected %b %b",
                         n, b_in_ready, b_out_valid, !pend, pend);
            end
            if (pend) begin
                checks++;
                if (b_out_data !== exp_d || b_out_count !== exp_c || b_out_ovf !== exp_o) begin
                    errors++;
                    $display("FAIL rand_frame cyc %0d data=%h cnt=%0d ovf=%b expected %h %0d %b",
                             n, b_out_data, b_out_count, b_out_ovf, exp_d, exp_c, exp_o);
                end
                if (b_out_ready) pend = 0;
            end else begin
                acc = b_in_valid;
                if (acc) q.push_back(b_in_data);
                if ((acc && q.size() == 4) || (b_flush && q.size() > 0)) begin
                    total = 0;
                    foreach (q[i]) total += longint'(q[i]);
                    exp_o = total >= lim;
`ifdef SUM_ACC_SAT_EN
                    exp_d = exp_o ? 18'h3FFFF : 18'(total);
`else
                    exp_d = 18'(total % lim);
`endif
                    exp_c = 3'(q.size());
                    pend  = 1;
                    q.delete();
                end
            end
            cyc();
        end
        b_in_valid  = 1'b0;
        b_flush     = 1'b0;
        b_out_ready = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_flush_with_accept();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream stage of the ripple-carry adder. Consumes the adder's WIDTH+1-bit result stream (sum plus carry-out) through a valid/ready handshake. Accumulates COUNT results into one frame sum and presents it on a registered valid/ready output. Supports early frame close (flush) and reports accumulator overflow.

Parameters:
WIDTH, 16, adder operand width; input sample is WIDTH+1 bits (carry-out in MSB)
ACC_W, 20, accumulator/output width; must be >= WIDTH+1 (elaboration error otherwise)
COUNT, 4, samples per full frame; must be >= 1
CNT_W, $clog2(COUNT+1), width of the beat counter and out_count

Ports:
clk  input  1  rising-edge clock, single domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample
in_data  input  WIDTH+1  adder result {carry, sum}, unsigned
flush  input  1  close the current partial frame
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts frame
out_data  output  ACC_W  frame sum
out_count  output  CNT_W  number of samples in the frame
out_ovf  output  1  an accumulation overflow occurred in this frame

Behaviour:
- Reset (async assert, sync release): state=ACC, acc=0, cnt=0, ovf=0; in_ready=0 during reset, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- States: ACC (collecting) and DONE (holding result).
- ACC: in_ready=1, out_valid=0. Accept = in_valid & in_ready.
  - On accept: acc <= acc + zero_extend(in_data) computed at ACC_W+1 bits. The extra bit sets ovf (sticky for the frame). cnt <= cnt+1.
  - Go to DONE when either condition holds, taking the updated acc/cnt/ovf into the out_* registers:
    - the accept makes cnt == COUNT;
    - flush=1 and (cnt > 0 or accept).
  - flush with cnt==0 and no accept: ignored, no empty frame emitted.
  - flush and accept in the same cycle: the beat is included, then the frame closes.
- DONE: in_ready=0; out_valid=1; out_data, out_count and out_ovf are stable until the handshake. flush is ignored.
  - On out_valid & out_ready: acc=0, cnt=0, ovf=0, state=ACC.
  - No input accept in the same cycle; in_ready rises the following cycle.
- Latency: the last accepted beat to out_valid is 1 cycle. Throughput is COUNT beats per COUNT+1 cycles minimum.
- Outputs are registered, with no combinational in→out path. in_ready depends only on state.
- Overflow without the feature: the sum wraps modulo 2^ACC_W and out_ovf=1.
- Reset mid-frame or in DONE: the partial frame and pending result are discarded. All outputs return to reset values immediately.
- in_data is sampled only on accept. Data while in_valid=0 is don't-care.

Optional Feature:
SUM_ACC_SAT_EN
- Defined: once overflow occurs, acc clamps to 2^ACC_W-1 and holds there for the rest of the frame. out_ovf=1.
- Undefined: the accumulator wraps modulo 2^ACC_W. out_ovf still flags overflow.
- Ports are identical in both builds.

Test Plan:
- Defaults, 4 back-to-back beats 0x00001,0x00002,0x00003,0x00004, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_data=0x0000A, out_count=4, out_ovf=0. in_ready=0 for exactly 1 cycle.
- Defaults, 4 beats of 0x1FFFF -> out_data=0x7FFFC, out_ovf=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- Defaults, 2 beats 0x00010,0x00020, then flush alone -> out_data=0x00030, out_count=2. flush with cnt==0 -> no out_valid.
- Flush asserted together with the 3rd accept of 0x00005 after 0x00001,0x00002 -> out_data=0x00008, out_count=3.
- ACC_W=18, beats 0x1FFFF,0x1FFFF,0x00002 then flush -> out_ovf=1. out_data=0x00000 without SUM_ACC_SAT_EN; 0x3FFFF with it.
- rst_n pulsed low mid-frame (cnt=2), then 4 beats of 0x00001 -> out_data=0x00004, out_count=4, out_ovf=0.
